// File: rtl/regwb_buffer_if.sv
// Writeback request bus into the register-file write buffer.
// Sources drive master; the buffer is the slave.
interface regwb_buffer_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_sel;
  logic [31:0] wb_dat;

  modport master (
    output wb_valid,
    output wb_sel,
    output wb_dat,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_sel,
    input  wb_dat,
    output wb_ready
  );
endinterface

// File: rtl/regwb_buffer.sv
// In-order writeback queue draining into the register file write port.
// Define REGWB_FWD_EN to enable pending-value forwarding lookups.
module regwb_buffer #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  regwb_buffer_if.slave    wb,
  input  logic             hold,
  output logic             rf_WEN,
  output logic [4:0]       rf_wsel,
  output logic [31:0]      rf_wdat,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  input  logic [4:0]       fwd_sel1,
  output logic             fwd_hit1,
  output logic [31:0]      fwd_dat1,
  input  logic [4:0]       fwd_sel2,
  output logic             fwd_hit2,
  output logic [31:0]      fwd_dat2
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       sel_q [DEPTH];
  logic [4:0]       sel_d [DEPTH];
  logic [31:0]      dat_q [DEPTH];
  logic [31:0]      dat_d [DEPTH];

  logic acc;
  logic drn;

  assign wb.wb_ready = (count_q != CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign rf_WEN      = !empty && !hold;
  assign rf_wsel     = rf_WEN ? sel_q[head_q] : '0;
  assign rf_wdat     = rf_WEN ? dat_q[head_q] : '0;

  // Writes to x0 complete the handshake but are never stored.
  assign acc = wb.wb_valid && wb.wb_ready && (wb.wb_sel != '0);
  assign drn = rf_WEN;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    if (drn) begin
      head_d        = head_q + 1'b1;
      vld_d[head_q] = 1'b0;
    end
    if (acc) begin
      tail_d        = tail_q + 1'b1;
      vld_d[tail_q] = 1'b1;
      sel_d[tail_q] = wb.wb_sel;
      dat_d[tail_q] = wb.wb_dat;
    end
    unique case (1'b1)
      (acc && !drn): count_d = count_q + 1'b1;
      (!acc && drn): count_d = count_q - 1'b1;
      default:       count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sel_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
  end

`ifdef REGWB_FWD_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    idx      = '0;
    fwd_hit1 = 1'b0;
    fwd_dat1 = '0;
    fwd_hit2 = 1'b0;
    fwd_dat2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && (fwd_sel1 != '0)
          && (sel_q[idx] == fwd_sel1)) begin
        fwd_hit1 = 1'b1;
        fwd_dat1 = dat_q[idx];
      end
      if (vld_q[idx] && (fwd_sel2 != '0)
          && (sel_q[idx] == fwd_sel2)) begin
        fwd_hit2 = 1'b1;
        fwd_dat2 = dat_q[idx];
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{fwd_sel1, fwd_sel2, vld_q};
  assign fwd_hit1   = 1'b0;
  assign fwd_dat1   = '0;
  assign fwd_hit2   = 1'b0;
  assign fwd_dat2   = '0;
`endif

endmodule

// File: tb/tb_regwb_buffer.sv
// Randomized bench for regwb_buffer against a queue-based model.
// Forwarding expectations follow REGWB_FWD_EN.
module tb_regwb_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] dat;
  } ent_t;

  logic             CLK;
  logic             nRST;
  logic             hold;
  logic             rf_WEN;
  logic [4:0]       rf_wsel;
  logic [31:0]      rf_wdat;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic [4:0]       fwd_sel1;
  logic             fwd_hit1;
  logic [31:0]      fwd_dat1;
  logic [4:0]       fwd_sel2;
  logic             fwd_hit2;
  logic [31:0]      fwd_dat2;

  regwb_buffer_if bus ();

  regwb_buffer #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .wb       (bus.slave),
    .hold     (hold),
    .rf_WEN   (rf_WEN),
    .rf_wsel  (rf_wsel),
    .rf_wdat  (rf_wdat),
    .count    (count),
    .empty    (empty),
    .fwd_sel1 (fwd_sel1),
    .fwd_hit1 (fwd_hit1),
    .fwd_dat1 (fwd_dat1),
    .fwd_sel2 (fwd_sel2),
    .fwd_hit2 (fwd_hit2),
    .fwd_dat2 (fwd_dat2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  ent_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fwd_model(input logic [4:0] s,
                           output logic hit,
                           output logic [31:0] dat);
    hit = 1'b0;
    dat = '0;
`ifdef REGWB_FWD_EN
    foreach (q[i]) begin
      if (s != 0 && q[i].sel == s) begin
        hit = 1'b1;
        dat = q[i].dat;
      end
    end
`endif
  endtask

  task automatic check_outputs();
    logic        wen;
    logic        h1, h2;
    logic [31:0] d1, d2;
    wen = (q.size() != 0) && !hold;
    check("wb_ready", bus.wb_ready, q.size() < DEPTH);
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("rf_WEN", rf_WEN, wen);
    check("rf_wsel", rf_wsel, wen ? q[0].sel : 5'd0);
    check("rf_wdat", rf_wdat, wen ? q[0].dat : 32'd0);
    fwd_model(fwd_sel1, h1, d1);
    fwd_model(fwd_sel2, h2, d2);
    check("fwd_hit1", fwd_hit1, h1);
    check("fwd_dat1", fwd_dat1, d1);
    check("fwd_hit2", fwd_hit2, h2);
    check("fwd_dat2", fwd_dat2, d2);
  endtask

  // One clock: drive at negedge, check, then apply the edge to the model.
  task automatic cycle(input logic v, input logic [4:0] s,
                       input logic [31:0] d, input logic h);
    logic acc_e, drn_e;
    bus.wb_valid = v;
    bus.wb_sel   = s;
    bus.wb_dat   = d;
    hold         = h;
    #1;
    check_outputs();
    acc_e = v && (q.size() < DEPTH);
    drn_e = (q.size() != 0) && !h;
    @(posedge CLK);
    if (drn_e) void'(q.pop_front());
    if (acc_e && s != 0) q.push_back('{sel: s, dat: d});
    @(negedge CLK);
  endtask

  initial begin
    nRST         = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_sel   = '0;
    bus.wb_dat   = '0;
    hold         = 1'b0;
    fwd_sel1     = '0;
    fwd_sel2     = '0;
    #1;
    check_outputs();
    @(negedge CLK);
    nRST = 1'b1;

    cycle(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
    check("beef_wen", rf_WEN, 1'b1);
    check("beef_dat", rf_wdat, 32'hDEAD_BEEF);
    cycle(1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0);

    for (int i = 1; i <= 5; i++)
      cycle(1'b1, 5'(i), 32'(i * 256), 1'b1);
    check("full_cnt", count, 4);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 5'd0, 32'd0, 1'b0);

    cycle(1'b1, 5'd0, 32'd5, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0);

    for (int i = 1; i <= 10; i++)
      cycle(1'b1, 5'(i), 32'(i * 16), 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0);

    fwd_sel1 = 5'd7;
    fwd_sel2 = 5'd0;
    cycle(1'b1, 5'd7, 32'h11, 1'b1);
    cycle(1'b1, 5'd7, 32'h22, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 5'd0, 32'd0, 1'b0);

    for (int i = 1; i <= 3; i++)
      cycle(1'b1, 5'(i + 8), 32'(i), 1'b1);
    bus.wb_valid = 1'b0;
    hold         = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    q.delete();
    check("rst_empty", empty, 1'b1);
    check("rst_wen", rf_WEN, 1'b0);
    check("rst_ready", bus.wb_ready, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 5'd0, 32'd0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      fwd_sel1 = 5'($urandom_range(0, 7));
      fwd_sel2 = 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 9) < 7,
            5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 9) < 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
